zorro_slot_arbiter: RTL
=======================

# zorro_slot_arbiter

Round-robin arbiter for the five Zorro III expansion-slot bus requests (EBR_n[4:0]). It sits beside `bus_arbitration` in the core. It requests the bus from the CPU side, issues EBG_n to one winning slot, and tracks ownership through EBGACK_n. It releases the bus back when the slot is done, or re-grants directly to the next pending slot. All decisions are taken on C7M rising edges, detected in the clk100 domain.

## Interface
- GRANT_TIMEOUT, 16: C7M rising edges allowed between EBG assertion and EBGACK before the grant is withdrawn.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (c7m_in, ebr_n_in, ebgack_n_in).
- clk100  in  1  system clock.
- reset_n_in  in  1  asynchronous, active-low reset.
- c7m_in  in  1  raw Zorro C7M clock; synchronized and edge-detected internally.
- ebr_n_in  in  5  slot bus requests; active low; asynchronous.
- ebgack_n_in  in  1  bus grant acknowledge from the granted master; active low; asynchronous.
- cpu_bus_released  in  1  level from `bus_arbitration`; CPU side has relinquished the bus.
- access_state_idle  in  1  access sequencer idle.
- cpu_bus_req  out  1  request for `bus_arbitration` to take the bus from the CPU.
- ebg_n_out  out  5  slot grants; active low; one-hot-low at most.
- ebg_n_oe  out  5  grant output enables.
- slot_owner  out  3  slot currently granted or owning the bus (0–4); 7 = none.
- timeout_pulse  out  1  one-clk100 strobe when a grant is withdrawn for lack of ack.

## Operation
- c7m_rise is a single clk100 strobe generated from the synchronized c7m_in (0→1). All FSM transitions, request sampling and timeout counting happen only on c7m_rise.
- Round-robin pick: the winner is the first slot with synchronized ebr_n low, searching from `last_slot+1` upward mod 5. `last_slot` updates to the winner when EBG is issued, so a timeout still advances the pointer. Reset value of `last_slot` is 4, so slot 0 has first priority.
- FSM states: IDLE, ACQUIRE, GRANT, OWNED, RELEASE.
  - IDLE: any ebr low → ACQUIRE and cpu_bus_req=1.
  - ACQUIRE: cpu_bus_released && access_state_idle → pick winner, assert its ebg_n, → GRANT. If all ebr go high first → IDLE and cpu_bus_req=0.
  - GRANT: ebgack low → deassert ebg_n and → OWNED. If the winner's ebr goes high, or the timeout counter reaches GRANT_TIMEOUT, → RELEASE. A timeout also pulses timeout_pulse. Ack beats both ebr-drop and timeout on the same edge.
  - OWNED: ebgack high → RELEASE.
  - RELEASE: all ebg_n high, slot_owner=7. If any ebr is low, pick the next winner and → GRANT with cpu_bus_req held at 1. Otherwise → IDLE and cpu_bus_req=0.
- The timeout counter is cleared on entry to GRANT and is 5 bits wide. It saturates and never wraps.
- A drop of cpu_bus_released during GRANT/OWNED is ignored; `bus_arbitration` guarantees the hold.
- Invariant: at most one ebg_n_out bit is low, in any state.
- Reset values, applied asynchronously: ebg_n_out=5'b11111, ebg_n_oe=5'b00000, cpu_bus_req=0, slot_owner=7, timeout_pulse=0, state=IDLE, last_slot=4.
- After reset release, ebg_n_oe=5'b11111 from the first clk100 edge onward.
- An asynchronous reset mid-grant forces all outputs to their reset values immediately. No grant survives reset.

## Timing
- Pin C7M rise → c7m_rise strobe: SYNC_STAGES+1 clk100 cycles.
- All outputs are registered and change in the clk100 cycle after c7m_rise. timeout_pulse is the exception: it is high for exactly that one cycle.
- Latency from an EBR edge to the first C7M sample: SYNC_STAGES clk100 cycles, then the next c7m_rise.
- Minimum from request to EBG: 2 C7M edges (IDLE→ACQUIRE, then ACQUIRE→GRANT with the bus already released).
- Re-grant through RELEASE: EBG of the next slot 2 C7M edges after the previous EBGACK deasserts. The bus is never returned to the CPU in between.

## Structure
- Shared package `zorro_arb_pkg` holds:
  - state encoding (IDLE..RELEASE);
  - NUM_SLOTS=5;
  - SLOT_NONE=3'd7;
  - the timeout counter width.
- Sub-module `zorro_rr_pick`: combinational round-robin picker. Inputs are the request vector and last_slot; outputs are winner and valid.
- The top module holds the synchronizers, the edge detect, the FSM, the counter and the output registers.

## Test plan
- Single request: ebr_n=5'b11011, CPU releases bus, ack after 3 C7M → ebg_n_out=5'b11011 for 3 C7M then 5'b11111, slot_owner=2, then 7 after ack release; cpu_bus_req falls in RELEASE→IDLE.
- Round-robin: slots 0, 1 and 4 request continuously, each acks and releases → grant order 0,1,4,0, no return to IDLE, cpu_bus_req stays 1.
- Timeout: slot 3 requests and never acks → EBG withdrawn after 16 C7M edges, timeout_pulse high for exactly 1 clk100, next grant goes to slot 4 (or IDLE if none pending).
- Simultaneous events: ebr drop and ebgack fall on the same C7M edge in GRANT → OWNED. Timeout and ack on the same edge → OWNED, no timeout_pulse.
- Request withdrawn in ACQUIRE: ebr_n back to 5'b11111 before cpu_bus_released → IDLE, no EBG ever asserted, cpu_bus_req=0.
- Reset mid-OWNED: reset_n_in low → ebg_n_out=5'b11111, ebg_n_oe=0, slot_owner=7 without any clock. After release, the first grant goes to slot 0.

Source files
------------

// File: rtl/zorro_arb_pkg.sv
// Shared types and constants for the Zorro III slot arbiter.
// Imported by the arbiter top and its round-robin picker.
package zorro_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_GRANT,
    ST_OWNED,
    ST_RELEASE
  } arb_state_e;

  localparam int NUM_SLOTS = 5;
  localparam logic [2:0] SLOT_NONE = 3'd7;
  localparam int TMO_W = 5;

  function automatic logic [NUM_SLOTS-1:0] grant_mask_n(
    input logic [2:0] slot
  );
    return ~(NUM_SLOTS'(1) << slot);
  endfunction

endpackage

// File: rtl/zorro_rr_pick.sv
// Combinational round-robin picker over the slot requests.
// Search starts at last_i+1 and wraps modulo NUM_SLOTS.
module zorro_rr_pick
  import zorro_arb_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] req_i,
  input  logic [2:0]           last_i,
  output logic [2:0]           winner_o,
  output logic                 valid_o
);

  logic [2:0] idx;

  // Walk from the farthest slot back so the nearest one wins.
  always_comb begin
    winner_o = SLOT_NONE;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      idx = 3'((int'(last_i) + k) % NUM_SLOTS);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zorro_slot_arbiter.sv
// Zorro III expansion-slot round-robin bus arbiter.
// Decisions are taken on synchronized C7M rising edges.
module zorro_slot_arbiter
  import zorro_arb_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk100,
  input  logic       reset_n_in,
  input  logic       c7m_in,
  input  logic [4:0] ebr_n_in,
  input  logic       ebgack_n_in,
  input  logic       cpu_bus_released,
  input  logic       access_state_idle,
  output logic       cpu_bus_req,
  output logic [4:0] ebg_n_out,
  output logic [4:0] ebg_n_oe,
  output logic [2:0] slot_owner,
  output logic       timeout_pulse
);

  localparam logic [TMO_W:0] TMO_LIM =
    (TMO_W+1)'(GRANT_TIMEOUT);

  logic [SYNC_STAGES-1:0] c7m_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [NUM_SLOTS-1:0]   ebr_sync_q [SYNC_STAGES];
  logic                   c7m_prev_q;
  logic                   rise_q;

  arb_state_e           state_q;
  logic [2:0]           last_q;
  logic [2:0]           owner_q;
  logic [TMO_W-1:0]     cnt_q;
  logic [NUM_SLOTS-1:0] ebg_q;
  logic [NUM_SLOTS-1:0] oe_q;
  logic                 bus_req_q;
  logic                 tp_q;

  logic [NUM_SLOTS-1:0] req;
  logic                 ack;
  logic                 any_req;
  logic [2:0]           pick_slot;
  logic                 pick_valid;
  logic [TMO_W:0]       cnt_inc;
  logic                 tmo_hit;

  always_ff @(posedge clk100 or negedge reset_n_in) begin
    if (!reset_n_in) begin
      c7m_sync_q <= '0;
      ack_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++)
        ebr_sync_q[i] <= '1;
      c7m_prev_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      c7m_sync_q <= {c7m_sync_q[SYNC_STAGES-2:0], c7m_in};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ebgack_n_in};
      ebr_sync_q[0] <= ebr_n_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        ebr_sync_q[i] <= ebr_sync_q[i-1];
      c7m_prev_q <= c7m_sync_q[SYNC_STAGES-1];
      rise_q     <= c7m_sync_q[SYNC_STAGES-1] & ~c7m_prev_q;
    end
  end

  assign req     = ~ebr_sync_q[SYNC_STAGES-1];
  assign ack     = ~ack_sync_q[SYNC_STAGES-1];
  assign any_req = |req;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign tmo_hit = cnt_inc >= TMO_LIM;

  zorro_rr_pick u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (pick_slot),
    .valid_o  (pick_valid)
  );

  always_ff @(posedge clk100 or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= ST_IDLE;
      last_q    <= 3'd4;
      owner_q   <= SLOT_NONE;
      cnt_q     <= '0;
      ebg_q     <= '1;
      oe_q      <= '0;
      bus_req_q <= 1'b0;
      tp_q      <= 1'b0;
    end else begin
      oe_q <= '1;
      tp_q <= 1'b0;
      if (rise_q) begin
        unique case (state_q)
          ST_IDLE: begin
            if (any_req) begin
              state_q   <= ST_ACQUIRE;
              bus_req_q <= 1'b1;
            end
          end
          ST_ACQUIRE: begin
            if (!any_req) begin
              state_q   <= ST_IDLE;
              bus_req_q <= 1'b0;
            end else if (cpu_bus_released &&
                         access_state_idle) begin
              state_q <= ST_GRANT;
              ebg_q   <= grant_mask_n(pick_slot);
              owner_q <= pick_slot;
              last_q  <= pick_slot;
              cnt_q   <= '0;
            end
          end
          // Ack wins over request drop, drop wins over timeout.
          ST_GRANT: begin
            if (ack) begin
              state_q <= ST_OWNED;
              ebg_q   <= '1;
            end else if (!req[owner_q]) begin
              state_q <= ST_RELEASE;
              ebg_q   <= '1;
              owner_q <= SLOT_NONE;
            end else if (tmo_hit) begin
              state_q <= ST_RELEASE;
              ebg_q   <= '1;
              owner_q <= SLOT_NONE;
              tp_q    <= 1'b1;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_inc[TMO_W-1:0];
            end
          end
          ST_OWNED: begin
            if (!ack) begin
              state_q <= ST_RELEASE;
              owner_q <= SLOT_NONE;
            end
          end
          ST_RELEASE: begin
            if (pick_valid) begin
              state_q <= ST_GRANT;
              ebg_q   <= grant_mask_n(pick_slot);
              owner_q <= pick_slot;
              last_q  <= pick_slot;
              cnt_q   <= '0;
            end else begin
              state_q   <= ST_IDLE;
              bus_req_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cpu_bus_req   = bus_req_q;
  assign ebg_n_out     = ebg_q;
  assign ebg_n_oe      = oe_q;
  assign slot_owner    = owner_q;
  assign timeout_pulse = tp_q;

endmodule
